rom_fetch_ctrl: RTL and testbench

Requester at the opposite end of the ROM-select timer handshake. On a fetch request it pulses start_timer and waits for the timer's ROMsel window. While the window is open it issues sequential ROM reads, then streams the returned words to the function-mux datapath. It reports completion, or an error if the window is missing or too short.

---
 rtl/rom_fetch_pkg.sv | 16 +
 rtl/rom_fetch_ctrl_stepper.sv | 32 +++
 rtl/rom_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared types and default sizing for the ROM fetch controller.
package rom_fetch_pkg;
  localparam int ADDR_W_DEF   = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int WINDOW_DEF   = 14;
  localparam int WAIT_MAX_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_SEL,
    FETCH,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/rom_fetch_ctrl_stepper.sv
// Address/length tracker: loads a start address and word count, steps with wrap.
module rom_addr_stepper #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              rem_zero
);
  logic [ADDR_W-1:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= load_addr;
      rem  <= load_len;
    end else if (step && (rem != '0)) begin
      addr <= addr + 1'b1;
      rem  <= rem - 1'b1;
    end
  end

  assign last     = (rem == ADDR_W'(1));
  assign rem_zero = (rem == '0);
endmodule

// File: rtl/rom_fetch_ctrl.sv
// ROM fetch requester: arms the ROM-select timer, reads inside its window, streams words out.
// Optional checksum output enabled by defining ROM_FETCH_CHECKSUM_EN.
//
// state    | meaning
// IDLE     | waiting for req
// ARM      | start_timer pulse
// WAIT_SEL | waiting for ROMsel, bounded by WAIT_MAX
// FETCH    | one read per ROMsel cycle until length exhausted
// DRAIN    | lets the last returned word through
// DONE     | done pulse, err qualifies it
module rom_fetch_ctrl
  import rom_fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WINDOW   = WINDOW_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              Clk,
  input  logic              Clear_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic              busy,
  output logic              start_timer,
  input  logic              ROMsel,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              done,
  output logic              err
`ifdef ROM_FETCH_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_MAX - 1);
  localparam logic [31:0] WINDOW_U = WINDOW;

  state_t            state, state_nxt;
  logic              err_flag, err_nxt;
  logic              accept, load_en, issue;
  logic              too_long;
  logic [WCNT_W-1:0] wcnt;
  logic [ADDR_W-1:0] cur_addr;
  logic              last, rem_zero;
  logic              busy_d, start_d, done_d, err_d;

  assign too_long = (32'(req_len) > WINDOW_U);
  assign word_out = rom_data;

  rom_addr_stepper #(.ADDR_W(ADDR_W)) u_stepper (
    .clk      (Clk),
    .rst_n    (Clear_n),
    .load     (load_en),
    .step     (issue),
    .load_addr(req_addr),
    .load_len (req_len),
    .addr     (cur_addr),
    .last     (last),
    .rem_zero (rem_zero)
  );

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state    <= IDLE;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_flag <= err_nxt;
    end
  end

  // A read is committed on the edge that samples ROMsel, so rom_rd lands the following cycle.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_flag;
    accept    = 1'b0;
    load_en   = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (req_len == '0) begin
            state_nxt = DONE;
            err_nxt   = 1'b0;
          end else if (too_long) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ARM;
            err_nxt   = 1'b0;
            load_en   = 1'b1;
          end
        end
      end
      ARM: state_nxt = WAIT_SEL;
      WAIT_SEL: begin
        if (ROMsel && !rem_zero) begin
          issue     = 1'b1;
          state_nxt = last ? DRAIN : FETCH;
        end else if (wcnt == '0) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      end
      FETCH: begin
        if (ROMsel && !rem_zero) begin
          issue = 1'b1;
          if (last) state_nxt = DRAIN;
        end else begin
          state_nxt = DRAIN;
          err_nxt   = !rem_zero;
        end
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_nxt != IDLE);
    start_d = (state_nxt == ARM);
    done_d  = (state_nxt == DONE);
    err_d   = done_d && err_nxt;
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      busy        <= 1'b0;
      start_timer <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rom_rd      <= 1'b0;
      rom_addr    <= '0;
      word_valid  <= 1'b0;
    end else begin
      busy        <= busy_d;
      start_timer <= start_d;
      done        <= done_d;
      err         <= err_d;
      rom_rd      <= issue;
      if (issue) rom_addr <= cur_addr;
      word_valid  <= rom_rd;
    end
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      wcnt <= '0;
    end else if (state == ARM) begin
      wcnt <= WCNT_LOAD;
    end else if ((state == WAIT_SEL) && (wcnt != '0)) begin
      wcnt <= wcnt - 1'b1;
    end
  end

`ifdef ROM_FETCH_CHECKSUM_EN
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (word_valid) begin
      checksum <= checksum ^ rom_data;
    end
  end
`endif
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a ROM-select timer model and a synchronous ROM model.
module tb_rom_fetch_ctrl;
  logic       Clk = 1'b0;
  logic       Clear_n;
  logic       req;
  logic [3:0] req_addr, req_len;
  logic       busy, start_timer, ROMsel, rom_rd, word_valid, done, err;
  logic [3:0] rom_addr;
  logic [7:0] rom_data, word_out;
`ifdef ROM_FETCH_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  rom_fetch_ctrl dut (
    .Clk(Clk), .Clear_n(Clear_n), .req(req), .req_addr(req_addr), .req_len(req_len),
    .busy(busy), .start_timer(start_timer), .ROMsel(ROMsel), .rom_rd(rom_rd),
    .rom_addr(rom_addr), .rom_data(rom_data), .word_out(word_out),
    .word_valid(word_valid), .done(done), .err(err)
`ifdef ROM_FETCH_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [16];
  int  sel_len = 14;
  int  sel_cnt = 0;
  logic       rd_prev = 1'b0;
  logic [3:0] addr_prev = '0;

  // timer raises ROMsel the cycle after start_timer for sel_len cycles; ROM answers one cycle after rom_rd
  always @(posedge Clk) begin
    #1;
    if (sel_cnt > 0) begin
      ROMsel = 1'b1;
      sel_cnt--;
    end else begin
      ROMsel = 1'b0;
    end
    if (start_timer) sel_cnt = sel_len;
    if (rd_prev) rom_data = mem[addr_prev];
    rd_prev   = rom_rd;
    addr_prev = rom_addr;
  end

  int cyc = 0;
  always @(posedge Clk) cyc++;

  int t_acc, t_rd1, t_wv1, t_done, n_rd, n_wv, n_done, n_st;
  int err_stray = 0;
  logic err_seen, busy_done;
  logic [3:0] addr_q [$];
  logic [7:0] word_q [$];

  always @(negedge Clk) begin
    if (req && !busy && t_acc < 0) t_acc = cyc;
    if (rom_rd) begin
      n_rd++;
      addr_q.push_back(rom_addr);
      if (t_rd1 < 0) t_rd1 = cyc;
    end
    if (word_valid) begin
      n_wv++;
      word_q.push_back(word_out);
      if (t_wv1 < 0) t_wv1 = cyc;
    end
    if (start_timer) n_st++;
    if (done) begin
      n_done++;
      t_done    = cyc;
      err_seen  = err;
      busy_done = busy;
    end
    if (err && !done) err_stray++;
  end

  task automatic clear_logs();
    t_acc = -1; t_rd1 = -1; t_wv1 = -1; t_done = -1;
    n_rd = 0; n_wv = 0; n_done = 0; n_st = 0;
    err_seen = 1'b0; busy_done = 1'b0;
    addr_q.delete();
    word_q.delete();
  endtask

  task automatic run_fetch(input logic [3:0] a, input logic [3:0] l, input int sl, input int second_at);
    clear_logs();
    sel_len = sl;
    @(posedge Clk); #2;
    req = 1'b1; req_addr = a; req_len = l;
    @(posedge Clk); #2;
    req = 1'b0;
    for (int i = 1; i <= 40 && n_done == 0; i++) begin
      if (second_at != 0 && i == second_at) begin
        req = 1'b1; req_addr = 4'd0; req_len = 4'd2;
      end else begin
        req = 1'b0;
      end
      @(posedge Clk); #2;
    end
    req = 1'b0;
    repeat (12) @(posedge Clk);
    #2;
  endtask

  task automatic check_fetch(input string nm, input logic [3:0] a, input int l, input int exp_done);
    logic [3:0] ea;
    check({nm, "_start_timer"}, n_st, 1);
    check({nm, "_reads"}, n_rd, l);
    check({nm, "_word_valid"}, n_wv, l);
    for (int k = 0; k < l; k++) begin
      ea = 4'(a + k);
      check($sformatf("%s_addr%0d", nm, k), (k < addr_q.size()) ? addr_q[k] : 4'hx, ea);
      check($sformatf("%s_word%0d", nm, k), (k < word_q.size()) ? word_q[k] : 8'hxx, mem[ea]);
    end
    check({nm, "_done_cnt"}, n_done, 1);
    check({nm, "_err"}, err_seen, 0);
    check({nm, "_first_rd"}, t_rd1 - t_acc, 3);
    check({nm, "_first_wv"}, t_wv1 - t_acc, 4);
    check({nm, "_done_at"}, t_done - t_acc, exp_done);
    check({nm, "_busy_at_done"}, busy_done, 1);
    check({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i * 7);
    mem[5] = 8'h12; mem[6] = 8'h34; mem[7] = 8'h0F;
    req = 1'b0; req_addr = '0; req_len = '0;
    ROMsel = 1'b0; rom_data = '0;
    clear_logs();
    Clear_n = 1'b1;
    #3 Clear_n = 1'b0;
    #1;
    check("reset_outputs", {busy, start_timer, rom_rd, rom_addr, word_valid, done, err}, 0);
    check("reset_word_out", word_out, rom_data);
`ifdef ROM_FETCH_CHECKSUM_EN
    check("reset_checksum", checksum, 0);
`endif
    repeat (3) @(posedge Clk);
    #2 Clear_n = 1'b1;
    repeat (2) @(posedge Clk);

    run_fetch(4'd3, 4'd4, 14, 0);
    check_fetch("basic", 4'd3, 4, 7);

    run_fetch(4'd14, 4'd4, 14, 0);
    check_fetch("wrap", 4'd14, 4, 7);

    run_fetch(4'd2, 4'd0, 14, 0);
    check("len0_start_timer", n_st, 0);
    check("len0_done_cnt", n_done, 1);
    check("len0_err", err_seen, 0);
    check("len0_done_at", t_done - t_acc, 1);
    check("len0_reads", n_rd, 0);

    run_fetch(4'd2, 4'd15, 14, 0);
    check("len15_start_timer", n_st, 0);
    check("len15_done_cnt", n_done, 1);
    check("len15_err", err_seen, 1);
    check("len15_done_at", t_done - t_acc, 1);

    run_fetch(4'd4, 4'd3, 0, 0);
    check("nosel_start_timer", n_st, 1);
    check("nosel_reads", n_rd, 0);
    check("nosel_done_cnt", n_done, 1);
    check("nosel_err", err_seen, 1);
    check("nosel_done_at", t_done - t_acc, 6);

    run_fetch(4'd9, 4'd5, 2, 0);
    check("short_reads", n_rd, 2);
    check("short_word_valid", n_wv, 2);
    check("short_addr0", (addr_q.size() > 0) ? addr_q[0] : 4'hx, 4'd9);
    check("short_addr1", (addr_q.size() > 1) ? addr_q[1] : 4'hx, 4'd10);
    check("short_done_cnt", n_done, 1);
    check("short_err", err_seen, 1);
    check("short_done_at", t_done - t_acc, 6);

    run_fetch(4'd8, 4'd6, 14, 3);
    check_fetch("busyreq", 4'd8, 6, 9);

    // reset in the middle of a fetch
    clear_logs();
    sel_len = 14;
    @(posedge Clk); #2;
    req = 1'b1; req_addr = 4'd0; req_len = 4'd8;
    @(posedge Clk); #2;
    req = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    check("midrst_reading", rom_rd, 1);
    Clear_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, start_timer, rom_rd, rom_addr, word_valid, done, err}, 0);
    repeat (2) @(posedge Clk);
    #2 Clear_n = 1'b1;
    repeat (16) @(posedge Clk);
    check("midrst_no_done", n_done, 0);

    run_fetch(4'd2, 4'd3, 14, 0);
    check_fetch("after_rst", 4'd2, 3, 6);

`ifdef ROM_FETCH_CHECKSUM_EN
    run_fetch(4'd5, 4'd3, 14, 0);
    check("cksum_reads", n_rd, 3);
    check("cksum_value", checksum, 8'h29);
`endif

    check("stray_err", err_stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
